// File: rtl/surf_regs_pkg.sv
// Shared definitions for the SURF identification/control register block:
// bus widths, decode window, register word indices, FSM state type and a
// byte-select mask helper.
package surf_regs_pkg;

   localparam int unsigned ADR_W = 22;
   localparam int unsigned DAT_W = 32;
   localparam int unsigned SEL_W = DAT_W / 8;
   localparam int unsigned WIN_W = 6;
   localparam int unsigned IDX_W = WIN_W - 2;

   localparam logic [IDX_W-1:0] ADDR_IDENT   = IDX_W'(0);
   localparam logic [IDX_W-1:0] ADDR_DATEVER = IDX_W'(1);
   localparam logic [IDX_W-1:0] ADDR_SCRATCH = IDX_W'(2);
   localparam logic [IDX_W-1:0] ADDR_CONTROL = IDX_W'(3);
   localparam logic [IDX_W-1:0] ADDR_PULSE   = IDX_W'(4);
   localparam logic [IDX_W-1:0] ADDR_STATUS  = IDX_W'(5);
   localparam logic [IDX_W-1:0] ADDR_UPTIME  = IDX_W'(6);

   typedef enum logic {IDLE, RESP} state_e;

   // Expand byte selects into a per-bit write mask.
   function automatic logic [DAT_W-1:0] sel_mask(input logic [SEL_W-1:0] sel);
      logic [DAT_W-1:0] m;
      m = '0;
      for (int unsigned b = 0; b < SEL_W; b++) begin
         m[8*b +: 8] = {8{sel[b]}};
      end
      return m;
   endfunction

endpackage

// File: rtl/surf_id_ctrl_if.sv
// WISHBONE slave-side bus bundle for the SURF register block.
// Signal names keep the slave's point of view (_i into slave, _o out of it).
//   master modport: drives cyc/stb/we/adr/dat_i/sel, receives dat_o/ack/err
//   slave  modport: the reverse
interface surf_id_ctrl_if;
   import surf_regs_pkg::*;

   logic             wb_cyc_i;
   logic             wb_stb_i;
   logic             wb_we_i;
   logic [ADR_W-1:0] wb_adr_i;
   logic [DAT_W-1:0] wb_dat_i;
   logic [SEL_W-1:0] wb_sel_i;
   logic [DAT_W-1:0] wb_dat_o;
   logic             wb_ack_o;
   logic             wb_err_o;

   modport master (
      output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i,
      input  wb_dat_o, wb_ack_o, wb_err_o
   );

   modport slave (
      input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i,
      output wb_dat_o, wb_ack_o, wb_err_o
   );
endinterface

// File: rtl/status_sticky.sv
// Sticky status bit array: bits set on set_i, cleared by write-1-to-clear.
// A set and a clear on the same edge leave the bit set.
//   clk_i  : clock          rst_ni : async active-low reset
//   set_i  : set events     clr_i  : clear strobes
//   q_o    : sticky bits (registered)
module status_sticky #(
   parameter int unsigned W = 16
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic [W-1:0] set_i,
   input  logic [W-1:0] clr_i,
   output logic [W-1:0] q_o
);

   logic [W-1:0] q_q;
   logic [W-1:0] q_d;

   always_comb begin
      q_d = (q_q & ~clr_i) | set_i;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         q_q <= '0;
      end else begin
         q_q <= q_d;
      end
   end

   assign q_o = q_q;

endmodule

// File: rtl/surf_id_ctrl.sv
// Registered WISHBONE responder for the SURF ident/control register window.
// Requests are sampled in IDLE, all side effects commit on that edge, and
// ack/err are presented for exactly one RESP cycle.
//   wb_clk_i  : register clock        wb_rst_ni : async active-low reset
//   wb        : WISHBONE slave bus bundle
//   ctrl_o    : CONTROL level bits    pulse_o   : one-cycle PULSE strobes
//   status_i  : sticky status events (wb_clk_i synchronous)
module surf_id_ctrl
   import surf_regs_pkg::*;
#(
   parameter logic [DAT_W-1:0] IDENT       = 32'h5355_5246,
   parameter logic [DAT_W-1:0] DATEVERSION = 32'h0,
   parameter int unsigned      NCTRL       = 16
) (
   input  logic             wb_clk_i,
   input  logic             wb_rst_ni,
   surf_id_ctrl_if.slave    wb,
   output logic [NCTRL-1:0] ctrl_o,
   output logic [NCTRL-1:0] pulse_o,
   input  logic [NCTRL-1:0] status_i
);

   state_e           state_q;
   logic             ack_q;
   logic             err_q;
   logic [DAT_W-1:0] dat_q;
   logic [DAT_W-1:0] scratch_q, scratch_d;
   logic [DAT_W-1:0] uptime_q;
   logic [NCTRL-1:0] ctrl_q, ctrl_d;
   logic [NCTRL-1:0] pulse_q, pulse_d;
   logic [NCTRL-1:0] stat_clr_c;
   logic [NCTRL-1:0] stat_q;

   logic             req_c;
   logic             win_c;
   logic             wr_c;
   logic [IDX_W-1:0] idx_c;
   logic [DAT_W-1:0] mask_c;
   logic [DAT_W-1:0] rdat_c;
   logic             unused_adr_c;

   // Byte offset bits carry no meaning for a word-wide register file.
   assign unused_adr_c = ^wb.wb_adr_i[1:0];

   // Decode, read mux and next-state of the writable registers.
   always_comb begin
      req_c  = (state_q == IDLE) && wb.wb_cyc_i && wb.wb_stb_i;
      win_c  = (wb.wb_adr_i[ADR_W-1:WIN_W] == '0);
      idx_c  = wb.wb_adr_i[WIN_W-1:2];
      wr_c   = req_c && win_c && wb.wb_we_i;
      mask_c = sel_mask(wb.wb_sel_i);

      rdat_c = '0;
      case (idx_c)
         ADDR_IDENT:   rdat_c = IDENT;
         ADDR_DATEVER: rdat_c = DATEVERSION;
         ADDR_SCRATCH: rdat_c = scratch_q;
         ADDR_CONTROL: rdat_c = DAT_W'(ctrl_q);
         ADDR_STATUS:  rdat_c = DAT_W'(stat_q);
         ADDR_UPTIME:  rdat_c = uptime_q;
         default:      rdat_c = '0;
      endcase

      scratch_d  = scratch_q;
      ctrl_d     = ctrl_q;
      pulse_d    = '0;
      stat_clr_c = '0;
      if (wr_c) begin
         case (idx_c)
            ADDR_SCRATCH: scratch_d  = (scratch_q & ~mask_c) | (wb.wb_dat_i & mask_c);
            ADDR_CONTROL: ctrl_d     = (ctrl_q & ~NCTRL'(mask_c)) |
                                       (NCTRL'(wb.wb_dat_i) & NCTRL'(mask_c));
            ADDR_PULSE:   pulse_d    = NCTRL'(wb.wb_dat_i);
            ADDR_STATUS:  stat_clr_c = NCTRL'(wb.wb_dat_i);
            default:      ;
         endcase
      end
   end

   // Bus FSM plus the registers it commits.
   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         state_q   <= IDLE;
         ack_q     <= 1'b0;
         err_q     <= 1'b0;
         dat_q     <= '0;
         scratch_q <= '0;
         ctrl_q    <= '0;
         pulse_q   <= '0;
         uptime_q  <= '0;
      end else begin
         uptime_q  <= uptime_q + DAT_W'(1);
         scratch_q <= scratch_d;
         ctrl_q    <= ctrl_d;
         pulse_q   <= pulse_d;
         case (state_q)
            IDLE: begin
               if (req_c) begin
                  state_q <= RESP;
                  ack_q   <= win_c;
                  err_q   <= !win_c;
                  dat_q   <= win_c ? rdat_c : '0;
               end
            end
            RESP: begin
               state_q <= IDLE;
               ack_q   <= 1'b0;
               err_q   <= 1'b0;
            end
            default: begin
               state_q <= IDLE;
               ack_q   <= 1'b0;
               err_q   <= 1'b0;
            end
         endcase
      end
   end

   status_sticky #(
      .W (NCTRL)
   ) u_status (
      .clk_i  (wb_clk_i),
      .rst_ni (wb_rst_ni),
      .set_i  (status_i),
      .clr_i  (stat_clr_c),
      .q_o    (stat_q)
   );

   assign wb.wb_dat_o = dat_q;
   assign wb.wb_ack_o = ack_q;
   assign wb.wb_err_o = err_q;
   assign ctrl_o      = ctrl_q;
   assign pulse_o     = pulse_q;

endmodule
